alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready in, valid/ready out, sticky carry for ADC.
// Define ALU_SEQ_MUL_EN to add the multi-cycle shift-add MUL (opcode 12).
module alu_seq #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
    OP_AND = 4'd4, OP_OR  = 4'd5, OP_NOT = 4'd6, OP_XOR = 4'd7,
    OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ADC = 4'd10, OP_CMP = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ALU_SEQ_MUL_EN
    S_BUSY,
`endif
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  op_e              op_c;
  logic [WIDTH-1:0] arith_y;
  logic             arith_sub, arith_cin, arith_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res, flag_src;
  logic             alu_c, alu_v, alu_z, alu_n, alu_err;
  logic             cf;

  assign op_c      = op_e'(op);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);
  logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_acc_next;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CNT_W-1:0]   mul_cnt;

  assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
`else
  logic unused_cfg;
  assign unused_cfg = (MUL_CYCLES != WIDTH);
`endif

  // One adder/subtractor at WIDTH+1 bits serves every arithmetic opcode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    arith_y   = b;
    arith_sub = 1'b0;
    arith_cin = 1'b0;
    case (op_c)
      OP_ADC:         arith_cin = cf;
      OP_INC:         arith_y   = ONE;
      OP_SUB, OP_CMP: arith_sub = 1'b1;
      OP_DEC: begin
        arith_sub = 1'b1;
        arith_y   = ONE;
      end
      default: ;
    endcase
    sum = arith_sub ? ({1'b0, a} - {1'b0, arith_y})
                    : ({1'b0, a} + {1'b0, arith_y} + {{WIDTH{1'b0}}, arith_cin});
    arith_v = arith_sub ? ((a[MSB] != arith_y[MSB]) && (sum[MSB] != a[MSB]))
                        : ((a[MSB] == arith_y[MSB]) && (sum[MSB] != a[MSB]));
  end

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    alu_v   = arith_v;
    alu_err = 1'b0;
    case (op_c)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC: ;
      OP_CMP: alu_res = a;
      OP_AND: begin alu_res = a & b; alu_c = 1'b0; alu_v = 1'b0; end
      OP_OR:  begin alu_res = a | b; alu_c = 1'b0; alu_v = 1'b0; end
      OP_NOT: begin alu_res = ~a;    alu_c = 1'b0; alu_v = 1'b0; end
      OP_XOR: begin alu_res = a ^ b; alu_c = 1'b0; alu_v = 1'b0; end
      OP_SHL: begin alu_res = {a[MSB-1:0], 1'b0}; alu_c = a[MSB]; alu_v = 1'b0; end
      OP_SHR: begin alu_res = {1'b0, a[MSB:1]};   alu_c = a[0];   alu_v = 1'b0; end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b1;
      end
    endcase
    // CMP reports the flags of a-b while passing a through as the result.
    flag_src = (op_c == OP_CMP) ? sum[WIDTH-1:0] : alu_res;
    alu_z    = !alu_err && (flag_src == '0);
    alu_n    = !alu_err && flag_src[MSB];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
`ifdef ALU_SEQ_MUL_EN
          if (op_c == OP_MUL) state_d = S_BUSY;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: if (mul_cnt == CNT_W'(MUL_CYCLES - 1)) state_d = S_DONE;
`endif
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      cf     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            result <= alu_res;
            carry  <= alu_c;
            zero   <= alu_z;
            neg    <= alu_n;
            ovf    <= alu_v;
            err    <= alu_err;
`ifdef ALU_SEQ_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, a};
            mul_mplier <= b;
            mul_cnt    <= '0;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_BUSY: begin
          mul_acc    <= mul_acc_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + CNT_W'(1);
          // Final step lands straight in the output registers.
          if (mul_cnt == CNT_W'(MUL_CYCLES - 1)) begin
            result <= mul_acc_next[WIDTH-1:0];
            carry  <= |mul_acc_next[2*WIDTH-1:WIDTH];
            zero   <= (mul_acc_next[WIDTH-1:0] == '0);
            neg    <= mul_acc_next[MSB];
            ovf    <= 1'b0;
            err    <= 1'b0;
          end
        end
`endif
        S_DONE: if (out_ready && !err) cf <= carry;
        default: ;
      endcase
    end
  end
endmodule
